// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and constants for the AES round sequencer
package aes_pkg;

  localparam int AES_NR_128  = 10;
  localparam int AES_BLOCK_W = 128;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERROR
  } seq_state_t;

  // Enum value doubles as the bit index on stage_start_out / stage_valid_in
  typedef enum logic [1:0] {
    ST_SB  = 2'd0,
    ST_SR  = 2'd1,
    ST_MC  = 2'd2,
    ST_ARK = 2'd3
  } stage_t;

  function automatic logic [3:0] stage_onehot(input stage_t s);
    return 4'b0001 << s;
  endfunction

endpackage

// File: rtl/aes_stage_watchdog.sv
// rtl/aes_stage_watchdog.sv - stage response watchdog (counter + compare)
module aes_stage_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear_in,
  input  logic count_in,
  output logic expired_out
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturating count of wait cycles since the last clear
  always_comb begin
    cnt_d = cnt_q;
    if (clear_in) begin
      cnt_d = '0;
    end else if (count_in && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires during the last allowed wait cycle
  assign expired_out = count_in && (cnt_q == LAST);

endmodule

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - AES-128 round sequencer; optional stage timeout via AES_SEQ_TIMEOUT_EN
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NR             = AES_NR_128,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   start_in,
  input  logic [AES_BLOCK_W-1:0] block_in,
  output logic                   ready_out,
  output logic [AES_BLOCK_W-1:0] result_out,
  output logic                   valid_out,
  output logic                   error_out,
  output logic [3:0]             key_idx_out,
  output logic [AES_BLOCK_W-1:0] stage_block_out,
  output logic [3:0]             stage_start_out,
  input  logic [3:0]             stage_valid_in,
  input  logic [AES_BLOCK_W-1:0] sb_result_in,
  input  logic [AES_BLOCK_W-1:0] sr_result_in,
  input  logic [AES_BLOCK_W-1:0] mc_result_in,
  input  logic [AES_BLOCK_W-1:0] ark_result_in
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  seq_state_t             state_q, state_d;
  stage_t                 stage_q, stage_d;
  logic [3:0]             round_q, round_d;
  logic [AES_BLOCK_W-1:0] blk_q, blk_d;
  logic [AES_BLOCK_W-1:0] res_q, res_d;
  logic                   valid_q, valid_d;
  logic                   act_valid;
  logic [AES_BLOCK_W-1:0] act_result;
  logic                   last_ark;
  logic                   timeout;

  // Only the active stage's valid and result are ever looked at
  always_comb begin
    act_valid  = stage_valid_in[stage_q];
    act_result = ark_result_in;
    case (stage_q)
      ST_SB:   act_result = sb_result_in;
      ST_SR:   act_result = sr_result_in;
      ST_MC:   act_result = mc_result_in;
      default: act_result = ark_result_in;
    endcase
  end

  assign last_ark = (stage_q == ST_ARK) && (round_q == LAST_ROUND);

`ifdef AES_SEQ_TIMEOUT_EN
  logic wd_expired;
  logic error_q, error_d;

  aes_stage_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .clear_in    (state_q == S_ISSUE),
    .count_in    (state_q == S_WAIT),
    .expired_out (wd_expired)
  );

  assign timeout = wd_expired;

  // Sticky error: set on timeout, cleared by the next accepted start
  always_comb begin
    error_d = error_q;
    if ((state_q == S_IDLE) && start_in) begin
      error_d = 1'b0;
    end else if ((state_q == S_WAIT) && !act_valid && wd_expired) begin
      error_d = 1'b1;
    end
  end

  // Error flag register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign error_out = error_q;
`else
  assign timeout   = 1'b0;
  assign error_out = 1'b0;
`endif

  // Next-state: walk ARK | (SB,SR,MC,ARK)x(NR-1) | SB,SR,ARK one stage at a time
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    round_d = round_q;
    blk_d   = blk_q;
    res_d   = res_q;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          blk_d   = block_in;
          round_d = 4'd0;
          stage_d = ST_ARK;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (act_valid) begin
          blk_d = act_result;
          if (last_ark) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            case (stage_q)
              ST_SB:   stage_d = ST_SR;
              ST_SR:   stage_d = (round_q == LAST_ROUND) ? ST_ARK : ST_MC;
              ST_MC:   stage_d = ST_ARK;
              default: begin
                stage_d = ST_SB;
                round_d = round_q + 4'd1;
              end
            endcase
          end
        end else if (timeout) begin
          state_d = S_ERROR;
        end
      end
      S_DONE: begin
        res_d   = blk_q;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      S_ERROR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state registers; reset aborts any block in flight
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      stage_q <= ST_ARK;
      round_q <= 4'd0;
      blk_q   <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      round_q <= round_d;
      blk_q   <= blk_d;
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  assign ready_out       = rst_in && (state_q == S_IDLE);
  assign result_out      = res_q;
  assign valid_out       = valid_q;
  assign key_idx_out     = round_q;
  assign stage_block_out = blk_q;
  assign stage_start_out = (state_q == S_ISSUE) ? stage_onehot(stage_q) : 4'b0000;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - self-checking bench for aes_round_sequencer
module tb_aes_round_sequencer;

  localparam int NR = 10;
  localparam int TO = 8;
  localparam logic [127:0] C_SB  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] C_SR  = 128'h13579bdf2468ace0fedcba9876543210;
  localparam logic [127:0] C_MC  = 128'hdeadbeefcafef00d0123456789abcdef;
  localparam logic [127:0] C_ARK = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] blk_in = '0;
  logic         ready_o, valid_o, err_o;
  logic [127:0] result_o, blk_o;
  logic [3:0]   key_o, start_o, stage_valid;
  logic [127:0] sb_d = '0, sr_d = '0, mc_d = '0, ark_d = '0;

  int           ls = 1;
  logic [3:0]   stall = 4'b0000;
  logic         noise_en = 1'b0;
  logic [3:0]   noise = 4'b0000;
  logic [3:0]   last_mask = 4'b0000;
  logic [7:0]   sh [4];
  logic [3:0]   stub_valid;

  int n_cmp = 0;
  int n_bad = 0;
  int vcnt = 0;
  int onehot_bad = 0;
  int lg_st[$];
  int lg_k[$];

  always #5 clk = ~clk;

  aes_round_sequencer #(.NR(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in          (clk),
    .rst_in          (rst_n),
    .start_in        (start),
    .block_in        (blk_in),
    .ready_out       (ready_o),
    .result_out      (result_o),
    .valid_out       (valid_o),
    .error_out       (err_o),
    .key_idx_out     (key_o),
    .stage_block_out (blk_o),
    .stage_start_out (start_o),
    .stage_valid_in  (stage_valid),
    .sb_result_in    (sb_d),
    .sr_result_in    (sr_d),
    .mc_result_in    (mc_d),
    .ark_result_in   (ark_d)
  );

  // Stage stubs: result = input ^ constant (ARK also mixes in the round index), valid after ls cycles
  always_comb begin
    for (int s = 0; s < 4; s++) stub_valid[s] = sh[s][ls-1];
  end
  assign stage_valid = stub_valid | (noise_en ? (noise & ~last_mask) : 4'b0000);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 4; s++) sh[s] <= 8'h00;
    end else begin
      for (int s = 0; s < 4; s++) sh[s] <= {sh[s][6:0], start_o[s] & ~stall[s]};
      if (start_o[0]) sb_d <= blk_o ^ C_SB;
      if (start_o[1]) sr_d <= blk_o ^ C_SR;
      if (start_o[2]) mc_d <= blk_o ^ C_MC;
      if (start_o[3]) ark_d <= blk_o ^ C_ARK ^ {32{key_o}};
    end
  end

  always @(negedge clk) noise <= 4'($urandom);

  // Monitor: log stage start pulses and count result pulses
  always @(posedge clk) begin
    if (valid_o) vcnt++;
    if (start_o != 4'b0000) begin
      lg_st.push_back($clog2(start_o));
      lg_k.push_back(int'(key_o));
      last_mask <= start_o;
      if (!$onehot(start_o)) onehot_bad++;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] b);
    logic [127:0] x;
    x = b;
    for (int r = 0; r <= NR; r++) begin
      if (r > 0) begin
        x ^= C_SB;
        x ^= C_SR;
        if (r < NR) x ^= C_MC;
      end
      x ^= C_ARK ^ {32{4'(r)}};
    end
    return x;
  endfunction

  // Called just after a negedge; returns at the negedge where valid_out is seen
  task automatic run(input logic [127:0] b, input bit hold, output int lat, output logic [127:0] res);
    lg_st.delete();
    lg_k.delete();
    start  = 1'b1;
    blk_in = b;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
    lat = 0;
    while (lat < 2000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (valid_o) break;
    end
    start = 1'b0;
    res = result_o;
  endtask

  task automatic check_order();
    int e_st[$];
    int e_k[$];
    int bad;
    int mc_last;
    e_st.push_back(3); e_k.push_back(0);
    for (int r = 1; r <= NR; r++) begin
      e_st.push_back(0); e_k.push_back(r);
      e_st.push_back(1); e_k.push_back(r);
      if (r < NR) begin e_st.push_back(2); e_k.push_back(r); end
      e_st.push_back(3); e_k.push_back(r);
    end
    bad = 0;
    mc_last = 0;
    if (lg_st.size() != e_st.size()) bad++;
    else begin
      for (int i = 0; i < e_st.size(); i++) begin
        if (lg_st[i] != e_st[i] || lg_k[i] != e_k[i]) bad++;
      end
    end
    for (int i = 0; i < lg_st.size(); i++) begin
      if (lg_st[i] == 2 && lg_k[i] == NR) mc_last++;
    end
    chk("start_count", lg_st.size(), 4 * NR);
    chk("order_mismatches", bad, 0);
    chk("mc_in_last_round", mc_last, 0);
  endtask

  initial begin
    int lat;
    int v0;
    int n;
    logic [127:0] res;
    logic [127:0] b;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_result", result_o, '0);
    chk("rst_valid", valid_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_error", err_o, 0);
    chk("rst_start", start_o, 0);
    chk("rst_key", key_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", ready_o, 1);

    // Directed block, Ls=1
    b = 128'h00112233445566778899aabbccddeeff;
    run(b, 0, lat, res);
    chk("lat_ls1", lat, 81);
    chk("result_directed", res, model(b));
    check_order();
    chk("onehot", onehot_bad, 0);

    // Random blocks, random Ls, back-to-back pairs
    for (int i = 0; i < 3; i++) begin
      repeat (12) @(negedge clk);
      ls = $urandom_range(1, 4);
      for (int j = 0; j < 2; j++) begin
        b = {$urandom, $urandom, $urandom, $urandom};
        run(b, 0, lat, res);
        chk("lat_rand", lat, 1 + 4 * NR * (ls + 1));
        chk("result_rand", res, model(b));
        chk("ready_at_valid", ready_o, 1);
      end
    end
    check_order();

    // start_in held while busy, spurious valids on inactive stages
    repeat (12) @(negedge clk);
    ls = 2;
    noise_en = 1'b1;
    v0 = vcnt;
    b = {$urandom, $urandom, $urandom, $urandom};
    run(b, 1, lat, res);
    repeat (6) @(negedge clk);
    noise_en = 1'b0;
    chk("hold_single_valid", vcnt - v0, 1);
    chk("hold_result", res, model(b));
    chk("hold_lat", lat, 1 + 4 * NR * 3);
    chk("hold_ready", ready_o, 1);
    chk("hold_result_held", result_o, model(b));

    // Reset mid-operation
    ls = 1;
    v0 = vcnt;
    start = 1'b1;
    blk_in = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_result", result_o, '0);
    chk("midrst_ready", ready_o, 0);
    chk("midrst_start", start_o, 0);
    chk("midrst_key", key_o, 0);
    chk("midrst_block", blk_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("midrst_no_valid", vcnt - v0, 0);
    b = {$urandom, $urandom, $urandom, $urandom};
    run(b, 0, lat, res);
    chk("post_rst_result", res, model(b));
    chk("post_rst_lat", lat, 81);

`ifdef AES_SEQ_TIMEOUT_EN
    // SR never answers: timeout after TO wait cycles
    repeat (12) @(negedge clk);
    stall = 4'b0010;
    v0 = vcnt;
    start = 1'b1;
    blk_in = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (start_o != 4'b0010 && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (!err_o && n < 50) begin @(negedge clk); n++; end
    chk("to_cycles", n, TO + 1);
    chk("to_ready_in_error", ready_o, 0);
    @(negedge clk);
    chk("to_ready_after", ready_o, 1);
    chk("to_error_sticky", err_o, 1);
    chk("to_no_valid", vcnt - v0, 0);
    chk("to_result_kept", result_o, res);
    stall = 4'b0000;
    b = {$urandom, $urandom, $urandom, $urandom};
    run(b, 0, lat, res);
    chk("to_cleared", err_o, 0);
    chk("to_next_result", res, model(b));
`else
    chk("error_tied_low", err_o, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
